pc_unit: RTL

//  Parametrised program-counter unit; successor to the datapath's fixed 10-bit PC.

---
 rtl/pc_unit_pkg.sv | 11 +
 rtl/pc_ras.sv | 57 +++++
 rtl/pc_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit.
// Holds the operation encodings driven by the control FSM.
package pc_unit_pkg;

   localparam logic [2:0] PC_INC    = 3'b000;
   localparam logic [2:0] PC_JUMP   = 3'b001;
   localparam logic [2:0] PC_BRANCH = 3'b010;
   localparam logic [2:0] PC_CALL   = 3'b011;
   localparam logic [2:0] PC_RET    = 3'b100;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a RAS_DEPTH x ADDR_W LIFO built from registers.
// Push and pop are never requested in the same cycle by the owner.
module pc_ras #(
   parameter int ADDR_W    = 10,
   parameter int RAS_DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [ADDR_W-1:0]            i_push_data,
   output logic [ADDR_W-1:0]            o_top,
   output logic [$clog2(RAS_DEPTH):0]   o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int IW = $clog2(RAS_DEPTH);
   localparam int CW = IW + 1;

   logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
   logic [CW-1:0]     r_count;
   logic [CW-1:0]     w_cnt_m1;
   logic [IW-1:0]     w_top_idx;
   logic [IW-1:0]     w_wr_idx;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_count == CW'(RAS_DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_cnt_m1  = r_count - CW'(1);
   assign w_top_idx = w_cnt_m1[IW-1:0];
   assign w_wr_idx  = r_count[IW-1:0];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   assign o_count = r_count;
   assign o_top   = o_empty ? '0 : r_stack[w_top_idx];

   // Storage is not reset; the count alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_stack[w_wr_idx] <= i_push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_do_push) begin
         r_count <= r_count + CW'(1);
      end else if (w_do_pop) begin
         r_count <= w_cnt_m1;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, PC register, call/return via
// the return-address stack, and sticky stack over/underflow flags.
module pc_unit
   import pc_unit_pkg::*;
#(
   parameter int                ADDR_W     = 10,
   parameter int                DISP_W     = 8,
   parameter int                RAS_DEPTH  = 8,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         pc_en,
   input  logic [2:0]                   op,
   input  logic                         cond,
   input  logic [ADDR_W-1:0]            target,
   input  logic [DISP_W-1:0]            disp,
   input  logic                         clr_err,
   output logic [ADDR_W-1:0]            pc_out,
   output logic [ADDR_W-1:0]            link_out,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_full,
   output logic                         ras_empty,
   output logic                         ras_ovf,
   output logic                         ras_unf
);

   logic [ADDR_W-1:0] r_pc;
   logic              r_ovf;
   logic              r_unf;
   logic [ADDR_W-1:0] w_pc_inc;
   logic [ADDR_W-1:0] w_disp_ext;
   logic [ADDR_W-1:0] w_pc_nxt;
   logic              w_push;
   logic              w_pop;
   logic              w_ovf_evt;
   logic              w_unf_evt;

   assign w_pc_inc   = r_pc + ADDR_W'(1);
   assign w_disp_ext = ADDR_W'($signed(disp));

   assign w_push    = pc_en && (op == PC_CALL) && !ras_full;
   assign w_pop     = pc_en && (op == PC_RET) && !ras_empty;
   assign w_ovf_evt = pc_en && (op == PC_CALL) && ras_full;
   assign w_unf_evt = pc_en && (op == PC_RET) && ras_empty;

   always_comb begin
      w_pc_nxt = w_pc_inc;
      case (op)
         PC_JUMP:   w_pc_nxt = target;
         PC_BRANCH: w_pc_nxt = cond ? (r_pc + w_disp_ext) : w_pc_inc;
         PC_CALL:   w_pc_nxt = target;
         PC_RET:    w_pc_nxt = ras_empty ? w_pc_inc : link_out;
         default:   w_pc_nxt = w_pc_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc <= RESET_ADDR;
      end else if (pc_en) begin
         r_pc <= w_pc_nxt;
      end
   end

   // A new error in the same cycle as clr_err leaves the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_ovf_evt)    r_ovf <= 1'b1;
         else if (clr_err) r_ovf <= 1'b0;
         if (w_unf_evt)    r_unf <= 1'b1;
         else if (clr_err) r_unf <= 1'b0;
      end
   end

   pc_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_push_data (w_pc_inc),
      .o_top       (link_out),
      .o_count     (ras_count),
      .o_full      (ras_full),
      .o_empty     (ras_empty)
   );

   assign pc_out  = r_pc;
   assign ras_ovf = r_ovf;
   assign ras_unf = r_unf;

endmodule
